// File: rtl/hyperbus_reg_responder.sv
// ---------------------------------------------------------------------------
// hyperbus_reg_responder
//
// Device-side model of the HyperRAM register space (ID0, ID1, CFG0, CFG1).
// Each clock carries at most one 16-bit SDR word. The first three valid words
// of a transaction are the command-address. Register writes commit on the
// first data word. Register reads return the addressed register once the
// configured initial latency has elapsed. The same value repeats until chip
// select rises.
//
// Ports
//   clk_i              clock
//   rst_ni             synchronous active-low reset
//   cs_ni              chip select, active low, frames one transaction
//   word_valid_i       word_i carries a CA or write-data word this cycle
//   word_i             CA word (MSB half first) or write data
//   refresh_pending_i  device requests double latency (variable mode only)
//   rwds_o             latency indicator, high during CA when latency doubled
//   rd_valid_o         rd_data_o carries register read data
//   rd_data_o          register read data
//   busy_o             a transaction is in progress
//   cfg0_o / cfg1_o    live configuration registers
// ---------------------------------------------------------------------------
module hyperbus_reg_responder #(
   parameter logic [15:0] ID0_VAL  = 16'h0C81,
   parameter logic [15:0] ID1_VAL  = 16'h0001,
   parameter logic [15:0] CFG0_RST = 16'h8F1F,
   parameter logic [15:0] CFG1_RST = 16'hFFC1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cs_ni,
   input  logic        word_valid_i,
   input  logic [15:0] word_i,
   input  logic        refresh_pending_i,
   output logic        rwds_o,
   output logic        rd_valid_o,
   output logic [15:0] rd_data_o,
   output logic        busy_o,
   output logic [15:0] cfg0_o,
   output logic [15:0] cfg1_o
);

   typedef enum logic [2:0] {
      IDLE,
      CA,
      WR_DATA,
      LAT,
      RD_DATA,
      IGNORE
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [1:0]  r_wordCnt;
   logic [31:0] r_addr;
   logic        r_isRead;
   logic        r_isReg;
   logic        r_double;
   logic [3:0]  r_latCnt;
   logic [15:0] r_cfg0;
   logic [15:0] r_cfg1;
   logic        r_rwds;
   logic        r_rdValid;
   logic [15:0] r_rdData;
   logic        r_busy;

   logic        w_firstWord;
   logic        w_caWord;
   logic        w_lastCa;
   logic        w_wrCommit;
   logic        w_doubleNow;
   logic        w_double;
   logic [3:0]  w_baseLat;
   logic [3:0]  w_effLat;
   logic [3:0]  w_latLoad;
   logic [15:0] w_readData;
   logic        w_rwdsNext;
   logic        w_rdValidNext;
   logic [15:0] w_rdDataNext;

   assign w_firstWord = (r_state == IDLE) && !cs_ni && word_valid_i;
   assign w_caWord    = (r_state == CA) && !cs_ni && word_valid_i;
   assign w_lastCa    = w_caWord && (r_wordCnt == 2'd2);
   assign w_wrCommit  = (r_state == WR_DATA) && !cs_ni && word_valid_i;

   // The doubling decision is taken on the first CA word. rwds then stays
   // constant for the whole CA phase, and the latency loaded on the last CA
   // word matches what rwds advertised.
   assign w_doubleNow = r_cfg0[3] | refresh_pending_i;
   assign w_double    = (r_state == IDLE) ? w_doubleNow : r_double;

   // Initial latency code in CFG0[7:4]. Unlisted codes fall back to 6 clocks.
   always_comb begin
      w_baseLat = 4'd6;
      unique case (r_cfg0[7:4])
         4'b0000: w_baseLat = 4'd5;
         4'b0001: w_baseLat = 4'd6;
         4'b0010: w_baseLat = 4'd7;
         4'b1110: w_baseLat = 4'd3;
         4'b1111: w_baseLat = 4'd4;
         default: w_baseLat = 4'd6;
      endcase
   end

   assign w_effLat  = r_double ? {w_baseLat[2:0], 1'b0} : w_baseLat;
   assign w_latLoad = w_effLat - 4'd1;

   // Register map lookup on the collected word address. CFG0[11:8] already
   // holds 4'hF because the write path forces those bits.
   always_comb begin
      w_readData = 16'h0000;
      unique case (r_addr)
         32'h0000_0000: w_readData = ID0_VAL;
         32'h0000_0001: w_readData = ID1_VAL;
         32'h0000_0800: w_readData = r_cfg0;
         32'h0000_0801: w_readData = r_cfg1;
         default:       w_readData = 16'h0000;
      endcase
   end

   // Next state and next output values. Chip select going high wins over
   // everything and returns the responder to IDLE. Outputs are derived from
   // the state being entered so that the registered copies line up with it.
   always_comb begin
      w_nextState   = r_state;
      w_rwdsNext    = 1'b0;
      w_rdValidNext = 1'b0;
      w_rdDataNext  = 16'h0000;
      if (cs_ni) begin
         w_nextState = IDLE;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (word_valid_i) w_nextState = CA;
            end
            CA: begin
               if (w_lastCa) begin
                  if (!r_isReg)     w_nextState = IGNORE;
                  else if (r_isRead) w_nextState = LAT;
                  else              w_nextState = WR_DATA;
               end
            end
            WR_DATA: begin
               if (word_valid_i) w_nextState = IGNORE;
            end
            LAT: begin
               if (r_latCnt == 4'd0) w_nextState = RD_DATA;
            end
            RD_DATA: w_nextState = RD_DATA;
            IGNORE:  w_nextState = IGNORE;
            default: w_nextState = IDLE;
         endcase
      end
      w_rwdsNext = (w_nextState == CA) && w_double;
      if (w_nextState == RD_DATA) begin
         w_rdValidNext = 1'b1;
         w_rdDataNext  = w_readData;
      end
   end

   // State, CA collection, latency counter, configuration registers and the
   // registered outputs. The word address is assembled as
   // {CA[44:32], CA[31:16], CA[2:0]}.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_wordCnt <= 2'd0;
         r_addr    <= 32'h0;
         r_isRead  <= 1'b0;
         r_isReg   <= 1'b0;
         r_double  <= 1'b0;
         r_latCnt  <= 4'd0;
         r_cfg0    <= CFG0_RST;
         r_cfg1    <= CFG1_RST;
         r_rwds    <= 1'b0;
         r_rdValid <= 1'b0;
         r_rdData  <= 16'h0000;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_rwds    <= w_rwdsNext;
         r_rdValid <= w_rdValidNext;
         r_rdData  <= w_rdDataNext;
         r_busy    <= (w_nextState != IDLE);

         if (w_firstWord) begin
            r_isRead  <= word_i[15];
            r_isReg   <= word_i[14];
            r_addr    <= {word_i[12:0], 19'h0};
            r_wordCnt <= 2'd1;
            r_double  <= w_doubleNow;
         end else if (w_caWord) begin
            if (r_wordCnt == 2'd1) r_addr[18:3] <= word_i;
            else                   r_addr[2:0]  <= word_i[2:0];
            r_wordCnt <= r_wordCnt + 2'd1;
         end

         if (w_lastCa) begin
            r_latCnt <= w_latLoad;
         end else if ((r_state == LAT) && (r_latCnt != 4'd0)) begin
            r_latCnt <= r_latCnt - 4'd1;
         end

         if (w_wrCommit) begin
            unique case (r_addr)
               32'h0000_0800: r_cfg0 <= {word_i[15:12], 4'hF, word_i[7:0]};
               32'h0000_0801: r_cfg1 <= word_i;
               default: begin
               end
            endcase
         end
      end
   end

   assign rwds_o     = r_rwds;
   assign rd_valid_o = r_rdValid;
   assign rd_data_o  = r_rdData;
   assign busy_o     = r_busy;
   assign cfg0_o     = r_cfg0;
   assign cfg1_o     = r_cfg1;

endmodule

// File: tb/tb_hyperbus_reg_responder.sv
// ---------------------------------------------------------------------------
// tb_hyperbus_reg_responder
//
// Directed bench for the HyperRAM register responder. It drives CA and data
// words one per clock. Inputs change 1 ns after the rising edge, and outputs
// are sampled at the same point. Expected values are computed by hand from
// the register map and the latency table.
// ---------------------------------------------------------------------------
module tb_hyperbus_reg_responder;

   logic        clk_i;
   logic        rst_ni;
   logic        cs_ni;
   logic        word_valid_i;
   logic [15:0] word_i;
   logic        refresh_pending_i;
   logic        rwds_o;
   logic        rd_valid_o;
   logic [15:0] rd_data_o;
   logic        busy_o;
   logic [15:0] cfg0_o;
   logic [15:0] cfg1_o;

   int checkCount = 0;
   int errorCount = 0;

   hyperbus_reg_responder dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .cs_ni             (cs_ni),
      .word_valid_i      (word_valid_i),
      .word_i            (word_i),
      .refresh_pending_i (refresh_pending_i),
      .rwds_o            (rwds_o),
      .rd_valid_o        (rd_valid_o),
      .rd_data_o         (rd_data_o),
      .busy_o            (busy_o),
      .cfg0_o            (cfg0_o),
      .cfg1_o            (cfg1_o)
   );

   // 100 MHz clock.
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of bus inputs, then sample just after the next edge.
   task automatic applyStimulus(input logic cs, input logic valid,
                                input logic [15:0] word);
      cs_ni        = cs;
      word_valid_i = valid;
      word_i       = word;
      @(posedge clk_i);
      #1;
   endtask

   // Full register read: check rwds during CA, the exact first-data cycle,
   // the repeat while CS stays low, and the drop once CS rises.
   task automatic readAndCheck(input string tag, input logic [15:0] w0,
                               input logic [15:0] w1, input logic [15:0] w2,
                               input int leff, input logic [15:0] expData,
                               input logic expRwds, input logic refresh);
      refresh_pending_i = refresh;
      applyStimulus(1'b0, 1'b1, w0);
      checkOutput({tag, " rwds ca1"}, 16'(rwds_o), 16'(expRwds));
      applyStimulus(1'b0, 1'b1, w1);
      checkOutput({tag, " rwds ca2"}, 16'(rwds_o), 16'(expRwds));
      applyStimulus(1'b0, 1'b1, w2);
      refresh_pending_i = 1'b0;
      for (int i = 1; i < leff; i++) applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput({tag, " not early"}, 16'(rd_valid_o), 16'h0);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput({tag, " valid"}, 16'(rd_valid_o), 16'h1);
      checkOutput({tag, " data"}, rd_data_o, expData);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput({tag, " repeat"}, rd_data_o, expData);
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput({tag, " valid drop"}, 16'(rd_valid_o), 16'h0);
      checkOutput({tag, " idle"}, 16'(busy_o), 16'h0);
   endtask

   // Register write: three CA words and one data word, then check both
   // configuration registers on the cycle after the data word.
   task automatic writeAndCheck(input string tag, input logic [15:0] w0,
                                input logic [15:0] w1, input logic [15:0] w2,
                                input logic [15:0] data,
                                input logic [15:0] expCfg0,
                                input logic [15:0] expCfg1);
      applyStimulus(1'b0, 1'b1, w0);
      applyStimulus(1'b0, 1'b1, w1);
      applyStimulus(1'b0, 1'b1, w2);
      applyStimulus(1'b0, 1'b1, data);
      checkOutput({tag, " cfg0"}, cfg0_o, expCfg0);
      checkOutput({tag, " cfg1"}, cfg1_o, expCfg1);
      applyStimulus(1'b1, 1'b0, 16'h0);
   endtask

   initial begin
      rst_ni            = 1'b0;
      cs_ni             = 1'b1;
      word_valid_i      = 1'b0;
      word_i            = 16'h0;
      refresh_pending_i = 1'b0;
      applyStimulus(1'b1, 1'b0, 16'h0);
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("reset rwds", 16'(rwds_o), 16'h0);
      checkOutput("reset rd_valid", 16'(rd_valid_o), 16'h0);
      checkOutput("reset rd_data", rd_data_o, 16'h0000);
      checkOutput("reset busy", 16'(busy_o), 16'h0);
      checkOutput("reset cfg0", cfg0_o, 16'h8F1F);
      checkOutput("reset cfg1", cfg1_o, 16'hFFC1);
      rst_ni = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0);

      // Default config: latency 6, fixed doubling -> 12 clocks, rwds high.
      readAndCheck("rd cfg0 default", 16'hC000, 16'h0100, 16'h0000, 12,
                   16'h8F1F, 1'b1, 1'b0);

      // Latency code 3 with fixed latency off; bits [11:8] read back as F.
      writeAndCheck("wr cfg0", 16'h6000, 16'h0100, 16'h0000, 16'h0EE0,
                    16'h0FE0, 16'hFFC1);

      readAndCheck("rd id0 norefresh", 16'hC000, 16'h0000, 16'h0000, 3,
                   16'h0C81, 1'b0, 1'b0);
      readAndCheck("rd id0 refresh", 16'hC000, 16'h0000, 16'h0000, 6,
                   16'h0C81, 1'b1, 1'b1);

      // Writes to read-only and unmapped addresses are dropped.
      writeAndCheck("wr id1", 16'h6000, 16'h0000, 16'h0001, 16'hFFFF,
                    16'h0FE0, 16'hFFC1);
      writeAndCheck("wr unmapped", 16'h6000, 16'h0000, 16'h0005, 16'h1234,
                    16'h0FE0, 16'hFFC1);
      readAndCheck("rd id1", 16'hC000, 16'h0000, 16'h0001, 3,
                   16'h0001, 1'b0, 1'b0);
      readAndCheck("rd unmapped", 16'hC000, 16'h0000, 16'h0005, 3,
                   16'h0000, 1'b0, 1'b0);

      // CFG1 is fully writable; a second data word must be discarded.
      applyStimulus(1'b0, 1'b1, 16'h6000);
      applyStimulus(1'b0, 1'b1, 16'h0100);
      applyStimulus(1'b0, 1'b1, 16'h0001);
      applyStimulus(1'b0, 1'b1, 16'h1234);
      checkOutput("wr cfg1", cfg1_o, 16'h1234);
      applyStimulus(1'b0, 1'b1, 16'h5678);
      checkOutput("wr cfg1 extra word", cfg1_o, 16'h1234);
      applyStimulus(1'b1, 1'b0, 16'h0);
      readAndCheck("rd cfg1", 16'hC000, 16'h0100, 16'h0001, 3,
                   16'h1234, 1'b0, 1'b0);

      // Memory-space read: no data, busy until CS rises.
      applyStimulus(1'b0, 1'b1, 16'h8000);
      applyStimulus(1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b0, 1'b1, 16'h0000);
      for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("mem rd no valid", 16'(rd_valid_o), 16'h0);
      checkOutput("mem rd busy", 16'(busy_o), 16'h1);
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("mem rd idle", 16'(busy_o), 16'h0);

      // CS rises after two CA words.
      applyStimulus(1'b0, 1'b1, 16'hC000);
      applyStimulus(1'b0, 1'b1, 16'h0100);
      checkOutput("abort ca busy", 16'(busy_o), 16'h1);
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("abort ca idle", 16'(busy_o), 16'h0);
      checkOutput("abort ca rwds", 16'(rwds_o), 16'h0);

      // CS rises after write CA with no data word: CFG1 untouched.
      applyStimulus(1'b0, 1'b1, 16'h6000);
      applyStimulus(1'b0, 1'b1, 16'h0100);
      applyStimulus(1'b0, 1'b1, 16'h0001);
      applyStimulus(1'b1, 1'b1, 16'hAAAA);
      checkOutput("abort wr idle", 16'(busy_o), 16'h0);
      checkOutput("abort wr cfg1", cfg1_o, 16'h1234);
      applyStimulus(1'b1, 1'b0, 16'h0);
      checkOutput("abort wr cfg1 later", cfg1_o, 16'h1234);

      // Reset asserted during LAT with CS still low.
      applyStimulus(1'b0, 1'b1, 16'hC000);
      applyStimulus(1'b0, 1'b1, 16'h0100);
      applyStimulus(1'b0, 1'b1, 16'h0000);
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("lat busy", 16'(busy_o), 16'h1);
      rst_ni = 1'b0;
      applyStimulus(1'b0, 1'b0, 16'h0);
      checkOutput("lat reset busy", 16'(busy_o), 16'h0);
      checkOutput("lat reset rd_valid", 16'(rd_valid_o), 16'h0);
      checkOutput("lat reset rwds", 16'(rwds_o), 16'h0);
      checkOutput("lat reset cfg0", cfg0_o, 16'h8F1F);
      checkOutput("lat reset cfg1", cfg1_o, 16'hFFC1);
      rst_ni = 1'b1;
      applyStimulus(1'b1, 1'b0, 16'h0);

      // Latency is back to the default doubled value after reset.
      readAndCheck("rd cfg0 after reset", 16'hC000, 16'h0100, 16'h0000, 12,
                   16'h8F1F, 1'b1, 1'b0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/hyperbus_reg_responder.md
# hyperbus_reg_responder

Device-side responder for the HyperRAM register address space (ID0, ID1, CFG0, CFG1), used as the memory-side counterpart of the controller in simulation and in the loopback bench. It consumes the command-address (CA) and data words of a HyperBus transaction as one 16-bit SDR word per clock, decodes register reads and writes, and returns read data after the configured initial latency. It holds the live CFG0/CFG1 contents that the rest of the device model uses for latency and burst behaviour.

## Interface
- `ID0_VAL`, 16'h0C81, read-only value of ID0.
- `ID1_VAL`, 16'h0001, read-only value of ID1.
- `CFG0_RST`, 16'h8F1F, CFG0 reset value (deep_power_done=1, drive_strength=0, reserved=4'hF, initial_latency=1, fixed_latency_enable=1, hybrid_burst_enable=1, burst_length=3).
- `CFG1_RST`, 16'hFFC1, CFG1 reset value.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; one clock, synchronous, active-low.
- `cs_ni`  in  1  chip select, active low; frames one transaction.
- `word_valid_i`  in  1  `word_i` carries a CA or write-data word this cycle.
- `word_i`  in  16  CA word (MSB half first) or write data.
- `refresh_pending_i`  in  1  device wants double latency (variable-latency mode only).
- `rwds_o`  out  1  latency indicator, driven during CA phase.
- `rd_valid_o`  out  1  `rd_data_o` valid.
- `rd_data_o`  out  16  register read data.
- `busy_o`  out  1  transaction in progress (state not IDLE).
- `cfg0_o`  out  16  current CFG0.
- `cfg1_o`  out  16  current CFG1.

## Operation
- States: IDLE, CA, WR_DATA, LAT, RD_DATA, IGNORE.
- IDLE -> CA when `cs_ni`=0 and `word_valid_i`=1; that word is CA[47:32]. Word counter (2 bits) collects CA[31:16], CA[15:0] on following valid words.
- CA fields: CA[47]=read, CA[46]=register space, word address = {CA[44:16], CA[2:0]}.
- After third CA word: CA[46]=0 -> IGNORE; write -> WR_DATA; read -> LAT.
- Register map (word addresses): ID0 0x0000, ID1 0x0001, CFG0 0x0800, CFG1 0x0801; any other address reads 16'h0000, writes dropped.
- WR_DATA: zero latency; first valid word commits. CFG0 writable bits [15:12],[7:0]; bits [11:8] always read 4'hF. CFG1 fully writable. ID writes dropped. Then IGNORE (further words discarded).
- Latency L from CFG0[7:4]: 0000=5, 0001=6, 0010=7, 1110=3, 1111=4, others=6. Effective latency Leff = 2L if CFG0[3]=1 or `refresh_pending_i` sampled at CA word 1 is 1; else L.
- `rwds_o`=1 during CA words when Leff=2L, else 0; 0 outside CA.
- LAT: down-counter loaded with Leff-1 on the third CA word; decrements every cycle; at 0 -> RD_DATA.
- RD_DATA: `rd_valid_o`=1 every cycle, `rd_data_o` = addressed register; repeats same value until `cs_ni` rises.
- IGNORE: outputs idle until `cs_ni` rises.
- `cs_ni`=1 in any state -> IDLE next cycle; partial CA discarded, uncommitted write discarded, `rd_valid_o` drops that cycle.

## Timing
- Reset values: state IDLE, `rwds_o`=0, `rd_valid_o`=0, `rd_data_o`=16'h0000, `busy_o`=0, `cfg0_o`=`CFG0_RST`, `cfg1_o`=`CFG1_RST`.
- All outputs registered.
- Read: third CA word at cycle t -> first `rd_valid_o`=1 at cycle t+Leff+1 (default config: Leff=12, first data at t+13).
- Write: data word at cycle t -> `cfg0_o`/`cfg1_o` updated at t+1.
- `word_valid_i`=0 during CA/WR_DATA stalls collection; latency counter runs on every cycle regardless.
- CFG0 write changes latency for the next transaction only.
- `rst_ni`=0 mid-transaction overrides `cs_ni`: registers return to reset values next edge.

## Test plan
- Reset, read CFG0 (CA 16'hC000,16'h0100,16'h0000) -> `rwds_o`=1 for CA words, data 16'h8F1F at third-CA+13, repeated while CS low.
- Write CFG0 = 16'h0EE0 (latency 3, fixed off) -> `cfg0_o`=16'h0FE0 next cycle; read ID0 with `refresh_pending_i`=0 -> `rwds_o`=0, 16'h0C81 at third-CA+4.
- Same config, `refresh_pending_i`=1 at CA word 1 -> `rwds_o`=1, data at third-CA+7.
- Write ID1 and unmapped 0x0005, then read both -> ID1 16'h0001, unmapped 16'h0000.
- Memory-space read (CA[46]=0) -> no `rd_valid_o`, `busy_o`=1 until CS high.
- CS rise after two CA words and after CA of a write (no data) -> IDLE next cycle, CFG unchanged; `rst_ni` low during LAT -> all reset values next cycle.
